// File: rtl/dcpu_pkg.sv
// -----------------------------------------------------------------------------
// dcpu_pkg
// Shared types for the DCPU board peripherals.
//   ps2_state_e     : PS/2 receiver frame FSM states
//   PS2_FRAME_BITS  : bits in one device-to-host PS/2 frame
//   scan_code_t     : one keyboard scan code byte
// -----------------------------------------------------------------------------
package dcpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // start + 8 data (LSB first) + odd parity + stop
    localparam int PS2_FRAME_BITS = 11;

    typedef logic [7:0] scan_code_t;

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 pin: a two-flop synchroniser followed by a
// persistence filter. The filtered level only follows the synchronised level
// once it has held a new value for FILTER_LEN consecutive cycles.
// Ports:
//   i_clk    : system clock
//   i_rst    : asynchronous active-high reset (line idles high)
//   i_line   : raw asynchronous pin level
//   o_level  : filtered line level
//   o_fall   : one-cycle pulse on each filtered 1->0 transition
// -----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchroniser depends
    // on this to stay two stages deep).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                // This cycle is the FILTER_LEN-th with a differing level.
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// Receive-only PS/2 device-to-host deserialiser with a scan-code FIFO.
// Frames (start, 8 data LSB first, odd parity, stop) are sampled on filtered
// PS2_CLK falling edges; good frames are queued and offered over valid/ready.
// Ports:
//   CLOCK_50, RESET        : 50 MHz clock, asynchronous active-high reset
//   PS2_CLK, PS2_DAT       : raw pin levels (never driven here)
//   code_data/code_valid   : FIFO head, first-word fall-through
//   code_ready             : consumer pops the head when code_valid is high
//   fifo_count             : queued entries
//   parity_err, frame_err,
//   overflow               : sticky error flags, cleared by err_clear
// -----------------------------------------------------------------------------
module ps2_rx
    import dcpu_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic                        PS2_CLK,
    input  logic                        PS2_DAT,
    output logic [7:0]                  code_data,
    output logic                        code_valid,
    input  logic                        code_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow,
    input  logic                        err_clear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    // ---------------------------------------------------------------- filters
    logic w_clk_fall;
    logic w_dat;
    logic w_unused_clk_level;
    logic w_unused_dat_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .i_clk   (CLOCK_50),
        .i_rst   (RESET),
        .i_line  (PS2_CLK),
        .o_level (w_unused_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .i_clk   (CLOCK_50),
        .i_rst   (RESET),
        .i_line  (PS2_DAT),
        .o_level (w_dat),
        .o_fall  (w_unused_dat_fall)
    );

    // -------------------------------------------------------------- frame FSM
    ps2_state_e    r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    scan_code_t    r_shreg, w_shreg_nxt;
    logic          r_par_ok, w_par_ok_nxt;
    logic [TW-1:0] r_tmo;
    logic          w_timeout;
    logic          w_push;
    logic          w_frame_set;
    logic          w_parity_set;

    // A fall pulse in the same cycle restarts the timeout window instead.
    assign w_timeout = (r_state != IDLE) && !w_clk_fall && (r_tmo == TW'(TIMEOUT));

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_par_ok_nxt  = r_par_ok;
        w_push        = 1'b0;
        w_frame_set   = 1'b0;
        w_parity_set  = 1'b0;

        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_frame_set = 1'b1;
        end else if (w_clk_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_dat) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_frame_set = 1'b1;
                    end
                end
                DATA: begin
                    w_shreg_nxt   = {w_dat, r_shreg[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    // Odd parity: data ones plus parity bit must be odd.
                    w_par_ok_nxt = ^r_shreg ^ w_dat;
                    w_state_nxt  = STOP;
                end
                STOP: begin
                    w_state_nxt  = IDLE;
                    w_push       = w_dat && r_par_ok;
                    w_frame_set  = !w_dat;
                    w_parity_set = !r_par_ok;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_par_ok  <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_par_ok  <= w_par_ok_nxt;
            if (w_clk_fall || w_timeout || r_state == IDLE) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    // The push is registered so the FIFO write sits one cycle after the stop
    // bit is seen.
    logic       r_push;
    scan_code_t r_push_data;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push      <= w_push;
            r_push_data <= r_shreg;
        end
    end

    // ------------------------------------------------------------------- FIFO
    scan_code_t    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_ovf_set;

    assign w_pop     = code_valid && code_ready;
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_wr      = r_push && (!w_full || w_pop);
    assign w_ovf_set = r_push && w_full && !w_pop;

    // NOTE: the storage array has no reset; only pointers and count do, and
    // code_data is forced to zero while empty so stale contents never leak.
    always_ff @(posedge CLOCK_50) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign code_valid = (r_count != '0);
    assign code_data  = code_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_count = r_count;

    // ----------------------------------------------------------- sticky flags
    // A set event in the same cycle as err_clear wins.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_parity_set)   parity_err <= 1'b1;
            else if (err_clear) parity_err <= 1'b0;
            if (w_frame_set)    frame_err  <= 1'b1;
            else if (err_clear) frame_err  <= 1'b0;
            if (w_ovf_set)      overflow   <= 1'b1;
            else if (err_clear) overflow   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx
// Drives PS/2 frames on the raw pins and compares every cycle against a
// frame-level model: each completed frame is judged from its bits (start,
// odd parity, stop) and its outcome is scheduled at the documented latency
// after the raw falling edge that carried the last bit.
// -----------------------------------------------------------------------------
module tb_ps2_rx;

    localparam int FL    = 8;
    localparam int TMO   = 10000;
    localparam int DEPTH = 8;

    localparam int EV_PUSH   = 0;
    localparam int EV_FRAME  = 1;
    localparam int EV_PARITY = 2;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       ps2_clk    = 1'b1;
    logic       ps2_dat    = 1'b1;
    logic       code_ready = 1'b0;
    logic       err_clear  = 1'b0;
    logic [7:0] code_data;
    logic       code_valid;
    logic [3:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    bit ready_manual = 1'b0;
    bit rand_en      = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat),
        .code_data  (code_data),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_clear  (err_clear)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: manual level, or a coin flip each cycle during random phases.
    always @(posedge clk) begin
        #2;
        code_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_manual;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        int         at;
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_par = 1'b0;
    bit         m_frm = 1'b0;
    bit         m_ovf = 1'b0;
    int         mask_lo = -100;
    int         mask_hi = -100;

    task automatic add_ev(input int at, input int kind, input logic [7:0] data);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.data = data;
        evq.push_back(e);
    endtask

    // Called at the raw falling edge (cycle n) of the last bit driven.
    task automatic model_last_fall(input logic [10:0] bits, input int nbits, input int n);
        bit par_ok;
        if (nbits == 11) begin
            par_ok = ^bits[9:1];
            if (bits[10] && par_ok) add_ev(n + FL + 4, EV_PUSH, bits[8:1]);
            if (!bits[10])          add_ev(n + FL + 3, EV_FRAME, 8'h00);
            if (!par_ok)            add_ev(n + FL + 3, EV_PARITY, 8'h00);
        end else begin
            // Abandoned frame: flagged once the clock has been silent TMO cycles.
            add_ev(n + FL + 4 + TMO, EV_FRAME, 8'h00);
            mask_lo = n + FL + 4 + TMO - 3;
            mask_hi = n + FL + 4 + TMO + 3;
        end
    endtask

    task automatic model_step();
        int         nxt;
        int         i;
        bit         s_par;
        bit         s_frm;
        bit         s_ovf;
        bit         have_push;
        bit         do_pop;
        logic [7:0] pd;
        if (rst) begin
            mq.delete();
            evq.delete();
            m_par = 1'b0;
            m_frm = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        check("code_valid", code_valid, (mq.size() != 0));
        check("fifo_count", fifo_count, mq.size());
        if (mq.size() != 0) check("code_data", code_data, mq[0]);
        check("parity_err", parity_err, m_par);
        check("overflow", overflow, m_ovf);
        if (!(cyc >= mask_lo && cyc <= mask_hi)) check("frame_err", frame_err, m_frm);

        // Effects of the coming clock edge.
        nxt       = cyc + 1;
        s_par     = 1'b0;
        s_frm     = 1'b0;
        s_ovf     = 1'b0;
        have_push = 1'b0;
        pd        = 8'h00;
        i         = 0;
        while (i < evq.size()) begin
            if (evq[i].at == nxt) begin
                case (evq[i].kind)
                    EV_PUSH:   begin have_push = 1'b1; pd = evq[i].data; end
                    EV_FRAME:  s_frm = 1'b1;
                    default:   s_par = 1'b1;
                endcase
                evq.delete(i);
            end else begin
                i++;
            end
        end
        do_pop = code_ready && (mq.size() > 0);
        if (have_push && mq.size() == DEPTH && !do_pop) s_ovf = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (have_push && !s_ovf) mq.push_back(pd);
        m_par = s_par ? 1'b1 : (err_clear ? 1'b0 : m_par);
        m_frm = s_frm ? 1'b1 : (err_clear ? 1'b0 : m_frm);
        m_ovf = s_ovf ? 1'b1 : (err_clear ? 1'b0 : m_ovf);
    endtask

    always @(negedge clk) model_step();

    // ---------------------------------------------------------------- drivers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: plain; 1: pin the push latency; 2: pop exactly on the push edge
    task automatic send_frame(input logic [7:0] data, input bit par_flip, input bit stop_bit,
                              input int nbits, input int half, input int mode);
        logic [10:0] bits;
        int          n;
        bits = {stop_bit, ~(^data) ^ par_flip, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            tick(half);
            ps2_clk = 1'b0;
            n = cyc;
            if (i == nbits - 1) model_last_fall(bits, nbits, n);
            if (i == 10 && mode == 1) begin
                tick(FL + 3);
                check("latency_before", code_valid, 1'b0);
                tick(1);
                check("latency_valid", code_valid, 1'b1);
                check("latency_data", code_data, 8'h1C);
                check("latency_flags", {parity_err, frame_err, overflow}, 3'b000);
                tick(half - FL - 4);
            end else if (i == 10 && mode == 2) begin
                tick(FL + 3);
                ready_manual = 1'b1;
                tick(1);
                ready_manual = 1'b0;
                tick(half - FL - 4);
            end else begin
                tick(half);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        tick(half);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        tick(1);
    endtask

    task automatic drain_all();
        ready_manual = 1'b1;
        tick(DEPTH + 3);
        ready_manual = 1'b0;
        tick(2);
        check("drain_all_empty", fifo_count, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        tick(3);
        check("reset_valid", code_valid, 1'b0);
        check("reset_data", code_data, 8'h00);
        check("reset_count", fifo_count, 0);
        check("reset_flags", {parity_err, frame_err, overflow}, 3'b000);
        rst = 1'b0;
        tick(FL + 5);

        // Good 0x1C at 12.5 kHz with the latency pinned.
        send_frame(8'h1C, 1'b0, 1'b1, 11, 2000, 1);
        drain_all();

        // 0xF0 with a wrong parity bit.
        send_frame(8'hF0, 1'b1, 1'b1, 11, 20, 0);
        check("badpar_flag", parity_err, 1'b1);
        check("badpar_count", fifo_count, 0);
        check("badpar_frame", frame_err, 1'b0);
        pulse_clear();
        check("badpar_cleared", parity_err, 1'b0);

        // Nine frames with no consumer: the ninth overflows.
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1, 11, 15, 0);
        check("ovf_count", fifo_count, 8);
        check("ovf_flag", overflow, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            check("ovf_drain_valid", code_valid, 1'b1);
            check("ovf_drain_data", code_data, 8'(k));
            ready_manual = 1'b1;
            tick(1);
        end
        ready_manual = 1'b0;
        check("ovf_drain_empty", fifo_count, 0);
        pulse_clear();

        // Frame abandoned after four data bits, then a good one.
        send_frame(8'h3C, 1'b0, 1'b1, 5, 20, 0);
        check("tmo_not_yet", frame_err, 1'b0);
        tick(TMO + 40);
        check("tmo_flag", frame_err, 1'b1);
        check("tmo_count", fifo_count, 0);
        pulse_clear();
        send_frame(8'h5A, 1'b0, 1'b1, 11, 20, 0);
        check("after_tmo_count", fifo_count, 1);
        check("after_tmo_data", code_data, 8'h5A);
        drain_all();

        // Short clock glitch while idle.
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(30);
        check("glitch_frame", frame_err, 1'b0);
        check("glitch_count", fifo_count, 0);

        // Reset in the middle of a frame with entries queued.
        for (int k = 0; k < 3; k++) send_frame(8'hA0 + 8'(k), 1'b0, 1'b1, 11, 20, 0);
        check("prerst_count", fifo_count, 3);
        send_frame(8'h77, 1'b0, 1'b1, 4, 20, 0);
        rst = 1'b1;
        #1;
        check("rst_valid", code_valid, 1'b0);
        check("rst_count", fifo_count, 0);
        tick(3);
        rst = 1'b0;
        tick(FL + 5);
        send_frame(8'h29, 1'b0, 1'b1, 11, 20, 0);
        check("postrst_count", fifo_count, 1);
        check("postrst_data", code_data, 8'h29);
        drain_all();

        // Full FIFO, consumer pops on the very edge the ninth push lands.
        for (int k = 0; k < 8; k++) send_frame(8'h40 + 8'(k), 1'b0, 1'b1, 11, 20, 0);
        check("full_count", fifo_count, 8);
        send_frame(8'h48, 1'b0, 1'b1, 11, 20, 2);
        check("fullpop_count", fifo_count, 8);
        check("fullpop_ovf", overflow, 1'b0);
        check("fullpop_head", code_data, 8'h41);
        drain_all();

        // Random frames against a random consumer.
        rand_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0),
                       !($urandom_range(0, 7) == 0), 11, $urandom_range(15, 40), 0);
            if ($urandom_range(0, 2) == 0) pulse_clear();
        end
        rand_en = 1'b0;
        tick(2);
        drain_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
